gpio_port_owner_arb: RTL and testbench
======================================

// Module: gpio_port_owner_arb
// PURPOSE
//  Per-port ownership arbiter for the expansion-header I/O ports (IOPorts x PortWidth pins).
//  Each port is driven by hostmot2 (default owner) or by an alternate requester (bit-bang/debug
//  engine). Request/grant handshake. Break-before-make guard tristates the port while ownership
//  changes. Sits between the hm2 IO mux and the GPIO header pin buffers.
// PARAMETERS
//  IOPorts       4    number of independently arbitrated ports
//  PortWidth     17   pins per port; IOWidth = IOPorts*PortWidth (68)
//  GUARD_CYCLES  16   clocks pin_oe is forced 0 on every ownership change; legal range 1..255
// PORTS
//  clk        in   1        system clock; all state on rising edge
//  reset      in   1        asynchronous, active-high
//  hm2_out    in   IOWidth  hostmot2 output data
//  hm2_oe     in   IOWidth  hostmot2 output enables
//  alt_out    in   IOWidth  alternate requester output data
//  alt_oe     in   IOWidth  alternate requester output enables
//  alt_req    in   IOPorts  bit k: alternate requester wants port k (level, held while owned)
//  port_lock  in   IOPorts  bit k: port k pinned to hostmot2; blocks/revokes alternate ownership
//  alt_grant  out  IOPorts  bit k: alternate owns port k, may drive
//  busy       out  IOPorts  bit k: port k in guard interval
//  pin_out    out  IOWidth  to pin buffers
//  pin_oe     out  IOWidth  to pin buffers, 1 = drive
// BEHAVIOUR
//  - One independent FSM + guard counter per port (cnt width = $clog2(GUARD_CYCLES)+1).
//    States: HM2, G2ALT, ALT, G2HM2.
//  - Reset (async): all ports HM2, cnt=0, alt_grant=0, busy=0.
//    While reset=1, pin_oe is forced all-0 combinationally and pin_out=0.
//  - HM2: pins = hm2_out/hm2_oe. If alt_req[k] & ~port_lock[k] is sampled: go G2ALT,
//    cnt <= GUARD_CYCLES-1.
//  - G2ALT: pin_oe=0, pin_out=0, busy=1.
//    cnt!=0 -> cnt-1. cnt==0 -> ALT.
//    If alt_req[k]=0 or port_lock[k]=1 is sampled at any point in G2ALT: abort to HM2 next edge.
//    No second guard is applied, because the alternate never drove the port.
//  - ALT: pins = alt_out/alt_oe, alt_grant=1.
//    alt_req[k]=0 or port_lock[k]=1 sampled -> G2HM2, cnt <= GUARD_CYCLES-1.
//  - G2HM2: pin_oe=0, pin_out=0, busy=1.
//    Count as in G2ALT, then -> HM2.
//    alt_req and port_lock are ignored until HM2 is reached; the port re-arbitrates on the
//    first cycle in HM2.
//  - Timing: alt_grant and busy are pure decodes of the state register, so they change the
//    cycle after the triggering edge.
//    pin_out/pin_oe are combinational muxes selected by the state register; no data-path
//    latency is added.
//    Guard = exactly GUARD_CYCLES clock cycles with pin_oe=0 on every full ownership change.
//  - Handshake: the requester must not drive external logic for port k until it sees
//    alt_grant[k]=1. Dropping alt_req[k] is the release. Grant falls the cycle after the
//    release is sampled, and the port is tristated from that same cycle.
//  - Simultaneous alt_req rise and port_lock=1: lock wins; the port stays in HM2.
//  - Ports are fully independent; events on different ports in the same cycle do not interact.
//  - Per-port slice: pins [k*PortWidth +: PortWidth] belong to port k.
// TESTING
//  1. Reset asserted mid-ALT on port 2 -> same cycle pin_oe=0x0; after release: all HM2,
//     alt_grant=0, pins = hm2.
//  2. GUARD=16: alt_req[0] first sampled at edge E0 -> busy[0]=1 and pin_oe[16:0]=0 for
//     exactly 16 cycles; alt_grant[0]=1 after E16; pins = alt_out[16:0]; other ports still hm2.
//  3. Port 1 in ALT, alt_req[1] dropped -> alt_grant[1]=0 next cycle; 16 cycles pin_oe[33:17]=0;
//     then hm2 data reappears.
//  4. alt_req[3] dropped at guard cycle 5 of G2ALT -> HM2 next cycle; no grant pulse; busy[3]
//     high 6 cycles total.
//  5. port_lock[2]=1 with alt_req[2]=1 held -> never granted. Lock asserted while port 2 is in
//     ALT -> revoked through the 16-cycle guard.
//  6. All 4 ports requested in the same cycle with GUARD=1 -> all grants rise together after
//     2 edges; random req/lock soak shows pin_oe never 1 from both owners in any cycle.

Source files
------------

// File: rtl/gpio_port_owner_arb.sv
// Per-port owner arbiter: hostmot2 vs alternate requester, with a break-before-make guard.
// Latency: grant/busy change the cycle after the sampling edge; pin data path is combinational.
// Backpressure: none; alt_req is a level request, alt_grant a level grant, lock revokes.
module gpio_port_owner_arb #(
  parameter int IOPorts      = 4,
  parameter int PortWidth    = 17,
  parameter int GUARD_CYCLES = 16,
  localparam int IOWidth     = IOPorts * PortWidth
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IOWidth-1:0] hm2_out,
  input  logic [IOWidth-1:0] hm2_oe,
  input  logic [IOWidth-1:0] alt_out,
  input  logic [IOWidth-1:0] alt_oe,
  input  logic [IOPorts-1:0] alt_req,
  input  logic [IOPorts-1:0] port_lock,
  output logic [IOPorts-1:0] alt_grant,
  output logic [IOPorts-1:0] busy,
  output logic [IOWidth-1:0] pin_out,
  output logic [IOWidth-1:0] pin_oe
);

  // Owner/guard states, kept as plain 2-bit codes for compatibility with older tooling.
  localparam logic [1:0] ST_HM2   = 2'd0;
  localparam logic [1:0] ST_G2ALT = 2'd1;
  localparam logic [1:0] ST_ALT   = 2'd2;
  localparam logic [1:0] ST_G2HM2 = 2'd3;

  localparam int CW = $clog2(GUARD_CYCLES) + 1;
  // Counter is loaded with GUARD_CYCLES-1 and the state moves on the edge that sees zero,
  // which gives exactly GUARD_CYCLES cycles spent in a guard state.
  localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYCLES - 1);

  logic [1:0]    state [IOPorts];
  logic [CW-1:0] cnt   [IOPorts];

  // A port is wanted by the alternate only while requested and not pinned to hostmot2.
  logic [IOPorts-1:0] want_alt;
  assign want_alt = alt_req & ~port_lock;

  // Per-port ownership FSM and guard counter; ports never interact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < IOPorts; k++) begin
        state[k] <= ST_HM2;
        cnt[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < IOPorts; k++) begin
        case (state[k])
          ST_HM2: begin
            if (want_alt[k]) begin
              state[k] <= ST_G2ALT;
              cnt[k]   <= GUARD_LOAD;
            end
          end
          ST_G2ALT: begin
            // Abort has priority over completion: the alternate never drove the
            // port, so hostmot2 can take it back without a second guard.
            if (!want_alt[k]) begin
              state[k] <= ST_HM2;
              cnt[k]   <= '0;
            end else if (cnt[k] == '0) begin
              state[k] <= ST_ALT;
            end else begin
              cnt[k] <= cnt[k] - 1'b1;
            end
          end
          ST_ALT: begin
            if (!want_alt[k]) begin
              state[k] <= ST_G2HM2;
              cnt[k]   <= GUARD_LOAD;
            end
          end
          ST_G2HM2: begin
            // Release guard runs to completion; request/lock are looked at again in HM2.
            if (cnt[k] == '0) begin
              state[k] <= ST_HM2;
            end else begin
              cnt[k] <= cnt[k] - 1'b1;
            end
          end
          default: begin
            state[k] <= ST_HM2;
            cnt[k]   <= '0;
          end
        endcase
      end
    end
  end

  // Status decodes and pin mux selected by the state register; pins tristate in guard and reset.
  always_comb begin
    alt_grant = '0;
    busy      = '0;
    pin_out   = '0;
    pin_oe    = '0;
    for (int k = 0; k < IOPorts; k++) begin
      alt_grant[k] = (state[k] == ST_ALT);
      busy[k]      = (state[k] == ST_G2ALT) || (state[k] == ST_G2HM2);
      if (!reset) begin
        if (state[k] == ST_HM2) begin
          pin_out[k*PortWidth +: PortWidth] = hm2_out[k*PortWidth +: PortWidth];
          pin_oe[k*PortWidth +: PortWidth]  = hm2_oe[k*PortWidth +: PortWidth];
        end else if (state[k] == ST_ALT) begin
          pin_out[k*PortWidth +: PortWidth] = alt_out[k*PortWidth +: PortWidth];
          pin_oe[k*PortWidth +: PortWidth]  = alt_oe[k*PortWidth +: PortWidth];
        end
      end
    end
  end

endmodule

// File: tb/tb_gpio_port_owner_arb.sv
// Bench for gpio_port_owner_arb: two instances (guard 16 and guard 1) share stimulus.
// Reference model tracks each port's owner phase and the cycle number the phase began.
// Directed scenarios followed by a random request/lock soak.
module tb_gpio_port_owner_arb;

  localparam int NP = 4;
  localparam int PW = 17;
  localparam int W  = NP * PW;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  hm2_out, hm2_oe, alt_out, alt_oe;
  logic [NP-1:0] alt_req, port_lock;

  logic [NP-1:0] grant_w [2];
  logic [NP-1:0] busy_w  [2];
  logic [W-1:0]  pout_w  [2];
  logic [W-1:0]  poe_w   [2];

  int checks = 0;
  int errors = 0;

  // Model: phase 0=hostmot2 owns, 1=guard toward alt, 2=alt owns, 3=guard toward hostmot2.
  int phase [2][NP];
  int start [2][NP];
  int guard [2] = '{16, 1};
  int cyc = 0;

  always #5 clk = ~clk;

  gpio_port_owner_arb #(.IOPorts(NP), .PortWidth(PW), .GUARD_CYCLES(16)) u_dut16 (
    .clk(clk), .reset(reset),
    .hm2_out(hm2_out), .hm2_oe(hm2_oe), .alt_out(alt_out), .alt_oe(alt_oe),
    .alt_req(alt_req), .port_lock(port_lock),
    .alt_grant(grant_w[0]), .busy(busy_w[0]), .pin_out(pout_w[0]), .pin_oe(poe_w[0])
  );

  gpio_port_owner_arb #(.IOPorts(NP), .PortWidth(PW), .GUARD_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .hm2_out(hm2_out), .hm2_oe(hm2_oe), .alt_out(alt_out), .alt_oe(alt_oe),
    .alt_req(alt_req), .port_lock(port_lock),
    .alt_grant(grant_w[1]), .busy(busy_w[1]), .pin_out(pout_w[1]), .pin_oe(poe_w[1])
  );

  function automatic logic [W-1:0] rnd_bus();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < NP; k++) begin
        phase[i][k] = 0;
        start[i][k] = 0;
      end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < NP; k++) begin
        bit go;
        go = alt_req[k] && !port_lock[k];
        case (phase[i][k])
          0: if (go) begin phase[i][k] = 1; start[i][k] = cyc; end
          1: if (!go) phase[i][k] = 0;
             else if (cyc - start[i][k] == guard[i]) phase[i][k] = 2;
          2: if (!go) begin phase[i][k] = 3; start[i][k] = cyc; end
          default: if (cyc - start[i][k] == guard[i]) phase[i][k] = 0;
        endcase
      end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic [NP-1:0] eg, eb;
      logic [W-1:0]  eo, ee;
      eg = '0; eb = '0; eo = '0; ee = '0;
      for (int k = 0; k < NP; k++) begin
        eg[k] = (phase[i][k] == 2);
        eb[k] = (phase[i][k] == 1) || (phase[i][k] == 3);
        if (!reset && phase[i][k] == 0) begin
          eo[k*PW +: PW] = hm2_out[k*PW +: PW];
          ee[k*PW +: PW] = hm2_oe[k*PW +: PW];
        end else if (!reset && phase[i][k] == 2) begin
          eo[k*PW +: PW] = alt_out[k*PW +: PW];
          ee[k*PW +: PW] = alt_oe[k*PW +: PW];
        end
      end
      checks++;
      assert (grant_w[i] === eg) else begin
        errors++; $error("FAIL grant[%0d] cyc %0d got %h exp %h", i, cyc, grant_w[i], eg);
      end
      checks++;
      assert (busy_w[i] === eb) else begin
        errors++; $error("FAIL busy[%0d] cyc %0d got %h exp %h", i, cyc, busy_w[i], eb);
      end
      checks++;
      assert (pout_w[i] === eo) else begin
        errors++; $error("FAIL pin_out[%0d] cyc %0d got %h exp %h", i, cyc, pout_w[i], eo);
      end
      checks++;
      assert (poe_w[i] === ee) else begin
        errors++; $error("FAIL pin_oe[%0d] cyc %0d got %h exp %h", i, cyc, poe_w[i], ee);
      end
    end
  endtask

  // One clock: new pin data mid-cycle, model advance at the edge, compare 1 time unit later.
  task automatic step();
    hm2_out = rnd_bus();
    hm2_oe  = rnd_bus();
    alt_out = rnd_bus();
    alt_oe  = rnd_bus();
    @(posedge clk);
    cyc++;
    if (reset) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  task automatic watch(input int n, input int i, input int k,
                       output int nbusy, output int ngrant);
    nbusy = 0;
    ngrant = 0;
    repeat (n) begin
      step();
      if (busy_w[i][k] === 1'b1) nbusy++;
      if (grant_w[i][k] === 1'b1) ngrant++;
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  initial begin
    int nb, ng;
    reset     = 1'b1;
    alt_req   = '0;
    port_lock = '0;
    hm2_out = '0; hm2_oe = '0; alt_out = '0; alt_oe = '0;
    model_reset();
    #1;
    check_all();
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset in the middle of an alternate ownership on port 2.
    alt_req = 4'b0100;
    repeat (18) step();
    expect_int("t1_grant2_before_reset", int'(grant_w[0][2]), 1);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    expect_int("t1_oe_zero_in_reset", int'(poe_w[0] == '0), 1);
    alt_req = '0;
    repeat (2) step();
    reset = 1'b0;
    step();
    expect_int("t1_grant_after_reset", int'(grant_w[0]), 0);
    expect_int("t1_pins_hm2", int'(pout_w[0] === hm2_out && poe_w[0] === hm2_oe), 1);

    // Full acquisition of port 0: exactly 16 guard cycles, then alternate data.
    alt_req = 4'b0001;
    watch(16, 0, 0, nb, ng);
    expect_int("t2_busy_cycles", nb, 16);
    expect_int("t2_no_early_grant", ng, 0);
    step();
    expect_int("t2_grant0", int'(grant_w[0][0]), 1);
    expect_int("t2_pins_alt", int'(poe_w[0][PW-1:0] === alt_oe[PW-1:0]), 1);
    expect_int("t2_others_hm2", int'(poe_w[0][W-1:PW] === hm2_oe[W-1:PW]), 1);

    // Release of port 1 after ownership: grant drops next cycle, 16 guard cycles.
    alt_req = 4'b0011;
    repeat (17) step();
    expect_int("t3_grant1", int'(grant_w[0][1]), 1);
    alt_req = 4'b0001;
    watch(20, 0, 1, nb, ng);
    expect_int("t3_release_busy", nb, 16);
    expect_int("t3_release_grant", ng, 0);
    expect_int("t3_hm2_back", int'(pout_w[0][2*PW-1:PW] === hm2_out[2*PW-1:PW]), 1);

    // Abort of port 3 during the acquisition guard: no grant, 6 busy cycles total.
    alt_req = 4'b1001;
    watch(6, 0, 3, nb, ng);
    alt_req = 4'b0001;
    watch(20, 0, 3, nb, ng);
    expect_int("t4_busy_after_abort", nb, 0);
    expect_int("t4_no_grant", ng, 0);

    // Lock blocks a held request, and revokes an established grant through the guard.
    alt_req   = 4'b0101;
    port_lock = 4'b0100;
    watch(30, 0, 2, nb, ng);
    expect_int("t5_locked_grant", ng, 0);
    expect_int("t5_locked_busy", nb, 0);
    port_lock = '0;
    repeat (17) step();
    expect_int("t5_grant2", int'(grant_w[0][2]), 1);
    port_lock = 4'b0100;
    watch(20, 0, 2, nb, ng);
    expect_int("t5_revoke_busy", nb, 16);
    expect_int("t5_revoke_grant", ng, 0);

    // All ports requested together on the guard-1 instance.
    alt_req   = '0;
    port_lock = '0;
    repeat (20) step();
    alt_req = 4'b1111;
    step();
    expect_int("t6_grant_after_1", int'(grant_w[1]), 0);
    step();
    expect_int("t6_grant_after_2", int'(grant_w[1]), 15);

    // Random request/lock soak; the model compares every output every cycle.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NP; k++) begin
        if ($urandom_range(0, 7) == 0) alt_req[k] = ~alt_req[k];
        if ($urandom_range(0, 23) == 0) port_lock[k] = ~port_lock[k];
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
